dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the core load/store path and a DMA/loader port.
//  Sits between the core datapath (ALU result as address, RDB as write data) and the data memory.
//  Stalls the core by dropping the PC load enable when the core loses arbitration.
//  Grants a new winner every cycle. The memory read is combinational, so read data returns in the grant cycle.
// PARAMETERS
//  AW         32  address width
//  DW         32  data width
//  STARVE_MAX 4   max consecutive cycles DMA may lose to the core before it is forced to win (>=1)
//  BURST_MAX  8   max consecutive locked DMA grants before the core gets one arbitration cycle (>=1)
// PORTS
//  clk         in   1   rising-edge clock
//  areset      in   1   asynchronous reset, active-high
//  core_req    in   1   core wants the memory this cycle (load or store)
//  core_we     in   1   core store
//  core_addr   in   AW  core byte address
//  core_wdata  in   DW  core store data
//  core_rdata  out  DW  load data returned to the core
//  core_stall  out  1   core lost arbitration; PC load and RegWrite are held off
//  dma_req     in   1   DMA access request
//  dma_we      in   1   DMA write
//  dma_lock    in   1   DMA asks to keep the grant on the next cycle (burst)
//  dma_addr    in   AW  DMA address
//  dma_wdata   in   DW  DMA write data
//  dma_rdata   out  DW  DMA read data
//  dma_ack     out  1   DMA access performed this cycle
//  mem_we      out  1   memory write enable
//  mem_addr    out  AW  memory address
//  mem_wd      out  DW  memory write data
//  mem_rd      in   DW  memory read data (combinational)
// BEHAVIOUR
//  State: FSM {ARB, DMA_LOCK}, starve_cnt [0..STARVE_MAX], burst_cnt [0..BURST_MAX].
//  Reset (areset=1, async): state=ARB, both counters=0.
//    While areset is high all grants are 0, so mem_we=0, mem_addr=0, mem_wd=0, core_stall=0, dma_ack=0.
//  Arbitration is combinational from the registered state and the current requests.
//    ARB: only one requester -> it wins.
//      Both requesting -> core wins, unless starve_cnt==STARVE_MAX, in which case DMA wins.
//    DMA_LOCK: DMA wins if dma_req=1. Core stalls if it requests.
//  Outputs:
//    Winner's addr/wdata/we drive mem_*.
//    No winner: mem_we=0, mem_addr=0, mem_wd=0.
//    core_rdata=mem_rd and dma_rdata=mem_rd at all times; each is valid only in its requester's grant cycle.
//    dma_ack = dma grant. core_stall = core_req & ~core_grant.
//  starve_cnt:
//    +1 (saturating) when dma_req=1 and DMA loses.
//    Cleared on any DMA grant or when dma_req=0.
//  Transitions:
//    ARB -> DMA_LOCK: DMA granted with dma_lock=1. burst_cnt <= 1.
//    DMA_LOCK stays while dma_req & dma_lock & burst_cnt<BURST_MAX. burst_cnt +1 per grant.
//    DMA_LOCK -> ARB: dma_req=0, dma_lock=0, or burst_cnt==BURST_MAX. burst_cnt <= 0.
//      The core gets priority in that ARB cycle, even if starve_cnt==STARVE_MAX.
//  The lock is honoured only from the cycle after the grant. dma_lock without dma_req is ignored.
//  Simultaneous write requests: only the winner's write reaches memory; the loser's write is not buffered.
//    The loser must hold its request.
//  Requesters hold addr/we/wdata stable while stalled or not acked.
//  areset during DMA_LOCK aborts the burst immediately; no partial write occurs in the reset cycle.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined:
//    adds outputs stat_core_stalls[15:0] and stat_dma_grants[15:0].
//    Saturating counters, cleared by areset.
//    +1 per core_stall cycle and per dma_ack cycle respectively.
//  Undefined: the ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. Core alone, store addr 0x10 data 0xA5A5A5A5:
//     mem_we=1, mem_addr=0x10, core_stall=0. A following load returns 0xA5A5A5A5 in the same cycle.
//  2. DMA alone, read addr 0x20: dma_ack=1 in the request cycle, dma_rdata=mem[0x20]. Core idle.
//  3. Both request continuously, no lock, STARVE_MAX=4:
//     core wins 4 cycles, DMA wins the 5th. Repeats 4:1. core_stall high exactly in DMA cycles.
//  4. DMA lock held, BURST_MAX=8, core requesting:
//     8 consecutive dma_acks, 1 core grant, then DMA re-locks.
//  5. Assert areset mid-burst (cycle 3 of 8):
//     mem_we=0 at once. After release, state ARB and a core request is granted on the first cycle.
//  6. DMEM_ARB_STATS_EN on, scenario 3 run for 50 cycles: stat_core_stalls=10, stat_dma_grants=10.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core load/store path and a DMA port.
// Optional DMEM_ARB_STATS_EN adds saturating stall/grant statistics counters.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic          dma_lock,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_core_stalls,
    output logic [15:0]   stat_dma_grants
`endif
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    typedef enum logic {ARB, DMA_LOCK} state_t;
    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [BW-1:0] burst_q, burst_d, burst_inc;
    logic          prio_q, prio_d;
    logic          locked, starved, stay, dma_grant, core_grant;
    // Grant decision, next-state logic and memory port muxing; reset forces every grant low
    always_comb begin
        locked     = state_q == DMA_LOCK;
        starved    = starve_q == SW'(STARVE_MAX);
        dma_grant  = ~areset & dma_req & (locked | ~core_req | (starved & ~prio_q));
        core_grant = ~areset & core_req & ~dma_grant;
        burst_inc  = burst_q + BW'(1);
        stay       = dma_grant & dma_lock & (locked ? burst_inc < BW'(BURST_MAX) : BURST_MAX > 1);
        state_d    = stay ? DMA_LOCK : ARB;
        burst_d    = stay ? (locked ? burst_inc : BW'(1)) : '0;
        prio_d     = ~stay & (locked | (dma_grant & dma_lock));
        starve_d   = (dma_grant | ~dma_req) ? '0 : starved ? starve_q : starve_q + SW'(1);
        mem_we     = dma_grant ? dma_we : core_grant & core_we;
        mem_addr   = dma_grant ? dma_addr : core_grant ? core_addr : '0;
        mem_wd     = dma_grant ? dma_wdata : core_grant ? core_wdata : '0;
        core_rdata = mem_rd;
        dma_rdata  = mem_rd;
        dma_ack    = dma_grant;
        core_stall = ~areset & core_req & ~core_grant;
    end
    // Arbitration state: lock FSM, burst length, DMA starvation and one-cycle core priority after a burst
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q  <= ARB;
            starve_q <= '0;
            burst_q  <= '0;
            prio_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            burst_q  <= burst_d;
            prio_q   <= prio_d;
        end
    end
`ifdef DMEM_ARB_STATS_EN
    // Saturating counts of core stall cycles and DMA grant cycles
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            stat_core_stalls <= '0;
            stat_dma_grants  <= '0;
        end else begin
            if (core_stall & ~&stat_core_stalls) stat_core_stalls <= stat_core_stalls + 16'd1;
            if (dma_ack & ~&stat_dma_grants) stat_dma_grants <= stat_dma_grants + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a small word memory.
module tb_dmem_arbiter;
    logic        clk, areset;
    logic        core_req, core_we, core_stall;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        dma_req, dma_we, dma_lock, dma_ack;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_core_stalls, stat_dma_grants;
`endif
    logic [31:0] mem [0:255];
    int          n_pass, n_total;

    dmem_arbiter dut (
        .clk(clk), .areset(areset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef DMEM_ARB_STATS_EN
        , .stat_core_stalls(stat_core_stalls), .stat_dma_grants(stat_dma_grants)
`endif
    );

    assign mem_rd = mem[mem_addr[9:2]];

    always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic dl, input logic [31:0] da,
                         input logic [31:0] dd);
        @(negedge clk);
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        dma_req = dr; dma_we = dw; dma_lock = dl; dma_addr = da; dma_wdata = dd;
        #1;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8] = 32'h1234_5678;
        areset = 1'b1;
        drive(1, 1, 32'h44, 32'h1, 1, 1, 1, 32'h48, 32'h2);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wd", mem_wd, 0);
        chk("rst_stall", core_stall, 0);
        chk("rst_ack", dma_ack, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        areset = 1'b0;
        drive(1, 1, 32'h10, 32'hA5A5_A5A5, 0, 0, 0, 0, 0);
        chk("t1_mem_we", mem_we, 1);
        chk("t1_mem_addr", mem_addr, 32'h10);
        chk("t1_mem_wd", mem_wd, 32'hA5A5_A5A5);
        chk("t1_stall", core_stall, 0);
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        chk("t1_load", core_rdata, 32'hA5A5_A5A5);
        chk("t1_load_we", mem_we, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 32'h20, 0);
        chk("t2_ack", dma_ack, 1);
        chk("t2_rdata", dma_rdata, 32'h1234_5678);
        chk("t2_addr", mem_addr, 32'h20);
        chk("t2_stall", core_stall, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 32'h100, 0, 1, 0, 0, 32'h180, 0);
            chk("t3_ack", dma_ack, (i % 5) == 4);
            chk("t3_stall", core_stall, (i % 5) == 4);
            chk("t3_addr", mem_addr, ((i % 5) == 4) ? 32'h180 : 32'h100);
        end
        for (int c = 0; c < 15; c++) begin
            drive(c != 13, 0, 32'h200, 0, 1, 0, 1, 32'h300, 0);
            chk("t4_ack", dma_ack, (c >= 4 && c <= 11) || c >= 13);
            chk("t4_stall", core_stall, c != 13 && ((c >= 4 && c <= 11) || c >= 13));
            if (c == 12) chk("t4_core_addr", mem_addr, 32'h200);
        end
        drive(1, 0, 32'h200, 0, 1, 1, 1, 32'h300, 32'hDEAD_BEEF);
        chk("t5_ack_before", dma_ack, 1);
        chk("t5_we_before", mem_we, 1);
        #2 areset = 1'b1;
        #1;
        chk("t5_we_rst", mem_we, 0);
        chk("t5_ack_rst", dma_ack, 0);
        chk("t5_addr_rst", mem_addr, 0);
        #3 areset = 1'b0;
        drive(1, 0, 32'h240, 0, 1, 0, 0, 32'h300, 0);
        chk("t5_no_write", mem[192], 0);
        chk("t5_core_stall", core_stall, 0);
        chk("t5_dma_ack", dma_ack, 0);
        chk("t5_core_addr", mem_addr, 32'h240);
`ifdef DMEM_ARB_STATS_EN
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        areset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        areset = 1'b0;
        chk("t6_stalls_rst", stat_core_stalls, 0);
        chk("t6_grants_rst", stat_dma_grants, 0);
        for (int i = 0; i < 50; i++) drive(1, 0, 32'h100, 0, 1, 0, 0, 32'h180, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_stalls", stat_core_stalls, 10);
        chk("t6_grants", stat_dma_grants, 10);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
